program_load_sequencer: RTL



---
 rtl/loader_pkg.sv | 19 +
 rtl/loader_checksum.sv | 27 ++
 rtl/program_load_sequencer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared constants and state type for the program-load sequencer.
package loader_pkg;

    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 8;
    localparam int DEPTH   = 16;
    localparam int CKSUM_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_HOLD,
        ST_RUN,
        ST_HALTED,
        ST_ERROR
    } loader_state_t;

endpackage

// File: rtl/loader_checksum.sv
// Running modulo-2^W sum of accepted stream bytes; used only when LOADER_CHECKSUM_EN is defined.
module loader_checksum #(
    parameter int W = loader_pkg::CKSUM_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         acc,
    input  logic [W-1:0] data,
    output logic         sum_zero
);

    logic [W-1:0] sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum <= '0;
        end else if (clear) begin
            sum <= '0;
        end else if (acc) begin
            sum <= sum + data;
        end
    end

    assign sum_zero = (sum == '0);

endmodule

// File: rtl/program_load_sequencer.sv
// Streams a program image into the RAM load port, then releases the CPU and watches for HLT.
// Build option LOADER_CHECKSUM_EN: final beat is a checksum byte that must zero the image sum.
//
// state  | meaning
// IDLE   | after reset, CPU held, waiting for start
// LOAD   | accepting stream bytes, one RAM write per accepted beat
// DRAIN  | final write on the RAM port, overflow/checksum verdict
// HOLD   | RAM released, CPU kept in reset for HOLD_CYCLES more cycles
// RUN    | CPU running, waiting for HLT
// HALTED | CPU halted after a good load
// ERROR  | overflow or bad checksum, CPU held
module program_load_sequencer #(
    parameter int ADDR_W      = loader_pkg::ADDR_W,
    parameter int DATA_W      = loader_pkg::DATA_W,
    parameter int DEPTH       = loader_pkg::DEPTH,
    parameter int HOLD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              ram_mode,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              cpu_hold,
    input  logic              cpu_hlt,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   load_count
);
    import loader_pkg::*;

    localparam logic [ADDR_W:0] CNT_FULL  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_LAST  = (ADDR_W+1)'(DEPTH-1);
    localparam logic [3:0]      HOLD_INIT = 4'(HOLD_CYCLES);

    loader_state_t state, state_nxt;
    logic [3:0]    hold_cnt;
    logic          ovf;
    logic          accept;
    logic          load_start;
    logic          wr;
    logic          ovf_beat;
    logic          cksum_bad;

    assign accept     = s_valid && s_ready;
    assign load_start = start && (state == ST_IDLE || state == ST_HALTED || state == ST_ERROR);

`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_t OVF_STATE = ST_ERROR;
    logic sum_zero;

    loader_checksum #(.W(CKSUM_W)) u_cksum (
        .clk      (clk),
        .reset    (reset),
        .clear    (load_start),
        .acc      (accept),
        .data     (s_data[CKSUM_W-1:0]),
        .sum_zero (sum_zero)
    );

    // The checksum beat and any beat past a full RAM never reach the write port.
    assign wr        = accept && !s_last && (load_count != CNT_FULL);
    assign ovf_beat  = accept && !s_last && (load_count == CNT_FULL);
    assign cksum_bad = !sum_zero;
`else
    // Overflow beat is still written; the error is raised after DRAIN.
    localparam loader_state_t OVF_STATE = ST_DRAIN;

    assign wr        = accept;
    assign ovf_beat  = accept && !s_last && (load_count == CNT_LAST);
    assign cksum_bad = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_HALTED, ST_ERROR: begin
                if (start) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                if (accept && s_last) state_nxt = ST_DRAIN;
                else if (ovf_beat)    state_nxt = OVF_STATE;
            end
            ST_DRAIN: state_nxt = (ovf || cksum_bad) ? ST_ERROR : ST_HOLD;
            ST_HOLD: begin
                if (hold_cnt == 4'd0) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (cpu_hlt) state_nxt = ST_HALTED;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            s_ready    <= 1'b0;
            ram_mode   <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_data   <= '0;
            cpu_hold   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            load_count <= '0;
            hold_cnt   <= '0;
            ovf        <= 1'b0;
        end else begin
            state    <= state_nxt;
            s_ready  <= (state_nxt == ST_LOAD);
            // RAM mode lingers one cycle past the last strobe so the write settles before release.
            ram_mode <= (state_nxt == ST_LOAD) || (state_nxt == ST_DRAIN) ||
                        (state == ST_DRAIN && state_nxt == ST_HOLD);
            ram_we   <= wr;
            cpu_hold <= (state_nxt != ST_RUN);
            busy     <= (state_nxt == ST_LOAD) || (state_nxt == ST_DRAIN) || (state_nxt == ST_HOLD);
            done     <= (state_nxt == ST_HALTED);
            err      <= (state_nxt == ST_ERROR);

            if (wr) begin
                ram_addr   <= load_count[ADDR_W-1:0];
                ram_data   <= s_data;
                load_count <= load_count + 1'b1;
            end

            if (load_start) begin
                load_count <= '0;
                ovf        <= 1'b0;
            end else if (ovf_beat) begin
                ovf <= 1'b1;
            end

            if (state == ST_DRAIN) begin
                hold_cnt <= HOLD_INIT;
            end else if (state == ST_HOLD && hold_cnt != 4'd0) begin
                hold_cnt <= hold_cnt - 1'b1;
            end
        end
    end

endmodule
